// File: rtl/alu_pkg.sv
// Shared ALU definitions: control encodings, flag bit positions, default widths
// and the requester identifier used to tag operations through the pipeline.
package alu_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int ALU_CTLW  = 2;

  localparam logic [ALU_CTLW-1:0] ALU_ADD = 2'b00;
  localparam logic [ALU_CTLW-1:0] ALU_SUB = 2'b01;
  localparam logic [ALU_CTLW-1:0] ALU_AND = 2'b10;
  localparam logic [ALU_CTLW-1:0] ALU_ORR = 2'b11;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

endpackage

// File: rtl/alu.sv
// Purely combinational ALU: ADD, SUB, AND, ORR with NZCV flags.
// SUB is a + ~b + 1, so C=1 means no borrow.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CTLW  = ALU_CTLW
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [CTLW-1:0]  ALUControl,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       ALUFlags
);

  logic             sub;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum;
  logic             carry;
  logic             ovf;

  // Shared adder for ADD/SUB plus the logic ops and flag generation
  always_comb begin
    sub      = (ALUControl == ALU_SUB);
    b_op     = sub ? ~b : b;
    sum      = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub};
    Result   = '0;
    carry    = 1'b0;
    ovf      = 1'b0;
    ALUFlags = '0;
    case (ALUControl)
      ALU_ADD, ALU_SUB: begin
        Result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
        ovf    = (a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: Result = a & b;
      ALU_ORR: Result = a | b;
      default: Result = '0;
    endcase
    ALUFlags[FLAG_N] = Result[WIDTH-1];
    ALUFlags[FLAG_Z] = (Result == '0);
    ALUFlags[FLAG_C] = carry;
    ALUFlags[FLAG_V] = ovf;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters: round-robin grant, valid/ready on
// both sides, operand register (S1) -> ALU -> result register (S2), and the
// response steered back to the requester that issued the operation.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CTLW  = ALU_CTLW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [CTLW-1:0]  req0_ctl,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [CTLW-1:0]  req1_ctl,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags
);

  logic             s1_valid;
  req_id_t          s1_id;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [CTLW-1:0]  s1_ctl;

  logic             s2_valid;
  req_id_t          s2_id;
  logic [WIDTH-1:0] s2_result;
  logic [3:0]       s2_flags;

  req_id_t          rr_last;
  logic [1:0]       grant;
  logic             owner_ready;
  logic             s2_hold;
  logic             s2_load;
  logic             s1_accept;
  logic             accept_any;
  req_id_t          acc_id;

  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_flags;

  // Grant, pipeline advance conditions and the handshake back to requesters
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (rr_last == REQ1) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
    owner_ready = (s2_id == REQ1) ? rsp_ready[1] : rsp_ready[0];
    s2_hold     = s2_valid & ~owner_ready;
    s2_load     = s1_valid & ~s2_hold;
    s1_accept   = ~s1_valid | s2_load;
    // Nothing is accepted while reset is held, even though S1 reads as free.
    req_ready   = grant & {2{s1_accept & reset}};
    accept_any  = |(req_valid & req_ready);
    acc_id      = req_ready[1] ? REQ1 : REQ0;
  end

  // ---- S1: operand register (control state and round-robin pointer) ----
  // S1 occupancy and the round-robin pointer advance only on acceptance
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_id    <= REQ0;
      rr_last  <= REQ1;
    end else if (accept_any) begin
      s1_valid <= 1'b1;
      s1_id    <= acc_id;
      rr_last  <= acc_id;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Operands are captured only on acceptance; their contents are don't-care while S1 is empty
  always_ff @(posedge clk) begin
    if (accept_any) begin
      s1_a   <= (acc_id == REQ1) ? req1_a   : req0_a;
      s1_b   <= (acc_id == REQ1) ? req1_b   : req0_b;
      s1_ctl <= (acc_id == REQ1) ? req1_ctl : req0_ctl;
    end
  end

  alu #(
    .WIDTH(WIDTH),
    .CTLW (CTLW)
  ) u_alu (
    .a         (s1_a),
    .b         (s1_b),
    .ALUControl(s1_ctl),
    .Result    (alu_result),
    .ALUFlags  (alu_flags)
  );

  // ---- S2: result register ----
  // Capture the ALU output when S1 drains, otherwise free S2 once its owner takes it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid  <= 1'b0;
      s2_id     <= REQ0;
      s2_result <= '0;
      s2_flags  <= '0;
    end else if (s2_load) begin
      s2_valid  <= 1'b1;
      s2_id     <= s1_id;
      s2_result <= alu_result;
      s2_flags  <= alu_flags;
    end else if (s2_valid && owner_ready) begin
      s2_valid  <= 1'b0;
    end
  end

  // Response is routed one-hot to the owner of the S2 entry
  always_comb begin
    rsp_valid  = 2'b00;
    if (s2_valid) rsp_valid = (s2_id == REQ1) ? 2'b10 : 2'b01;
    rsp_result = s2_result;
    rsp_flags  = s2_flags;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed operations per requester are queued, a driver
// presents them, the monitor records acceptances into a scoreboard of
// hand-computed results and checks every response taken by its owner.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]  req0_ctl, req1_ctl;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  ctl;
    logic [31:0] r;
    logic [3:0]  f;
  } op_t;

  typedef struct {
    logic        id;
    logic [31:0] r;
    logic [3:0]  f;
    int          cyc;
  } exp_t;

  op_t   stim0[$];
  op_t   stim1[$];
  exp_t  sb[$];
  int    accept_log[$];
  int    resp_cyc[$];
  logic [1:0] acc;
  int    cyc;
  int    checks;
  int    errors;
  bit    lat_chk;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req0_ctl  (req0_ctl),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .req1_ctl  (req1_ctl),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_result(rsp_result),
    .rsp_flags (rsp_flags)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input int who, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] ctl, input logic [31:0] r, input logic [3:0] f);
    op_t o;
    o.a = a; o.b = b; o.ctl = ctl; o.r = r; o.f = f;
    if (who == 0) stim0.push_back(o);
    else          stim1.push_back(o);
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((stim0.size() != 0 || stim1.size() != 0 || sb.size() != 0 ||
            acc != 2'b00 || rsp_valid != 2'b00) && n < budget) begin
      tick();
      n++;
    end
    check("drain_in_budget", 64'(n < budget), 64'd1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    stim0.delete();
    stim1.delete();
    sb.delete();
    acc = 2'b00;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; rsp_ready = 2'b00; req_valid = 2'b00;
    req0_a = '0; req0_b = '0; req0_ctl = '0;
    req1_a = '0; req1_b = '0; req1_ctl = '0;
    acc = 2'b00; cyc = 0; checks = 0; errors = 0; lat_chk = 1'b0;

    fork
      // driver: retire accepted ops, present the next one of each requester
      begin
        forever begin
          @(posedge clk);
          #1;
          cyc++;
          if (acc[0]) begin void'(stim0.pop_front()); acc[0] = 1'b0; end
          if (acc[1]) begin void'(stim1.pop_front()); acc[1] = 1'b0; end
          if (stim0.size() > 0) begin
            req_valid[0] = 1'b1; req0_a = stim0[0].a; req0_b = stim0[0].b; req0_ctl = stim0[0].ctl;
          end else req_valid[0] = 1'b0;
          if (stim1.size() > 0) begin
            req_valid[1] = 1'b1; req1_a = stim1[0].a; req1_b = stim1[0].b; req1_ctl = stim1[0].ctl;
          end else req_valid[1] = 1'b0;
        end
      end
      // monitor: log acceptances into the scoreboard, check taken responses
      begin
        exp_t e;
        op_t  o;
        forever begin
          @(negedge clk);
          if (req_ready != 2'b00)
            check("req_ready_grant",
                  64'((req_ready == 2'b01 && req_valid[0]) || (req_ready == 2'b10 && req_valid[1])), 64'd1);
          for (int i = 0; i < 2; i++) begin
            if (req_valid[i] && req_ready[i]) begin
              o = (i == 0) ? stim0[0] : stim1[0];
              e.id = i[0]; e.r = o.r; e.f = o.f; e.cyc = cyc;
              sb.push_back(e);
              acc[i] = 1'b1;
              accept_log.push_back(i);
            end
          end
          if (rsp_valid != 2'b00) begin
            check("rsp_valid_onehot", 64'(rsp_valid == 2'b01 || rsp_valid == 2'b10), 64'd1);
            if (rsp_ready[rsp_valid[1]]) begin
              if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stale_response actual rsp_valid=%b result=%h required no response", rsp_valid, rsp_result);
              end else begin
                e = sb.pop_front();
                check("rsp_owner", 64'(rsp_valid), 64'(e.id ? 2'b10 : 2'b01));
                check("rsp_result", 64'(rsp_result), 64'(e.r));
                check("rsp_flags", 64'(rsp_flags), 64'(e.f));
                if (lat_chk) check("latency", 64'(cyc - e.cyc), 64'd2);
                resp_cyc.push_back(cyc);
              end
            end
          end
        end
      end
    join_none

    // reset state
    repeat (2) tick();
    check("reset_req_ready", 64'(req_ready), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_result", 64'(rsp_result), 64'd0);
    check("reset_rsp_flags", 64'(rsp_flags), 64'd0);
    reset = 1'b1;
    tick();

    // single ops with latency check
    rsp_ready = 2'b11;
    lat_chk = 1'b1;
    push(0, 32'h00000001, 32'hFFFFFFFF, 2'b00, 32'h00000000, 4'b0110);
    wait_idle(20);
    push(1, 32'h00000005, 32'h00000007, 2'b01, 32'hFFFFFFFE, 4'b1000);
    wait_idle(20);
    lat_chk = 1'b0;

    // both requesters streaming: strict alternation, no bubbles
    do_reset();
    accept_log.delete();
    resp_cyc.delete();
    push(0, 32'd10,         32'd20,         2'b00, 32'd30,         4'b0000);
    push(1, 32'h80000000, 32'h80000000, 2'b00, 32'h00000000, 4'b0111);
    push(0, 32'hFF00FF00, 32'h0F0F0F0F, 2'b10, 32'h0F000F00, 4'b0000);
    push(1, 32'h00000000, 32'h00000001, 2'b01, 32'hFFFFFFFF, 4'b1000);
    push(0, 32'h00000003, 32'h00000003, 2'b01, 32'h00000000, 4'b0110);
    push(1, 32'hFFFFFFFF, 32'h80000000, 2'b10, 32'h80000000, 4'b1000);
    push(0, 32'h00000000, 32'h00000000, 2'b11, 32'h00000000, 4'b0100);
    push(1, 32'h12345678, 32'h11111111, 2'b00, 32'h23456789, 4'b0000);
    wait_idle(40);
    check("rr_accept_count", 64'(accept_log.size()), 64'd8);
    for (int j = 0; j < 8 && j < accept_log.size(); j++)
      check("rr_accept_order", 64'(accept_log[j]), 64'(j % 2));
    check("rr_resp_count", 64'(resp_cyc.size()), 64'd8);
    if (resp_cyc.size() == 8)
      check("rr_no_bubbles", 64'(resp_cyc[7] - resp_cyc[0]), 64'd7);

    // backpressure on requester 0 (only the non-owner bit of rsp_ready is high)
    rsp_ready = 2'b10;
    push(0, 32'h00000001, 32'h00000001, 2'b00, 32'h00000002, 4'b0000);
    push(0, 32'h00000002, 32'h00000002, 2'b00, 32'h00000004, 4'b0000);
    push(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 32'hFFFFFFFE, 4'b1010);
    push(0, 32'h80000000, 32'h00000001, 2'b01, 32'h7FFFFFFF, 4'b0011);
    push(0, 32'h00001234, 32'h000000FF, 2'b10, 32'h00000034, 4'b0000);
    repeat (4) tick();
    for (int k = 0; k < 3; k++) begin
      check("hold_req_ready", 64'(req_ready), 64'd0);
      check("hold_rsp_valid", 64'(rsp_valid), 64'b01);
      check("hold_rsp_result", 64'(rsp_result), 64'h2);
      check("hold_rsp_flags", 64'(rsp_flags), 64'd0);
      tick();
    end
    rsp_ready = 2'b11;
    wait_idle(40);

    // overflow and ORR flags
    push(0, 32'h7FFFFFFF, 32'h00000001, 2'b00, 32'h80000000, 4'b1001);
    push(1, 32'hF0F00000, 32'h0000F0F0, 2'b11, 32'hF0F0F0F0, 4'b1000);
    wait_idle(20);

    // reset pulse with S1 and S2 occupied
    rsp_ready = 2'b00;
    push(0, 32'h00000011, 32'h00000022, 2'b00, 32'h00000033, 4'b0000);
    push(0, 32'h00000044, 32'h00000011, 2'b01, 32'h00000033, 4'b0010);
    push(0, 32'h000000F0, 32'h0000000F, 2'b11, 32'h000000FF, 4'b0000);
    repeat (4) tick();
    check("full_before_reset", 64'(rsp_valid), 64'b01);
    reset = 1'b0;
    #1;
    check("mid_reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_reset_req_ready", 64'(req_ready), 64'd0);
    check("mid_reset_rsp_result", 64'(rsp_result), 64'd0);
    stim0.delete();
    stim1.delete();
    sb.delete();
    acc = 2'b00;
    rsp_ready = 2'b11;
    tick();
    reset = 1'b1;
    repeat (5) tick();
    check("no_stale_after_reset", 64'(rsp_valid), 64'd0);
    accept_log.delete();
    push(0, 32'h00000100, 32'h00000200, 2'b00, 32'h00000300, 4'b0000);
    push(1, 32'h00000001, 32'h00000002, 2'b01, 32'hFFFFFFFF, 4'b1000);
    wait_idle(20);
    check("post_reset_accepts", 64'(accept_log.size()), 64'd2);
    if (accept_log.size() > 0)
      check("post_reset_tie_req0", 64'(accept_log[0]), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
